// File: rtl/issue_stage_pkg.sv
// Shared types for the issue stage: register index / value types, the decoded
// and issued instruction records, the writeback record and the opcode constants.
package issue_stage_pkg;

    localparam int NREG = 32;
    localparam int XLEN = 32;

    typedef logic [4:0]      reg_idx;
    typedef logic [XLEN-1:0] gpreg;
    typedef logic [3:0]      op_t;

    localparam op_t INSTR_OP_ADD  = 4'd0;
    localparam op_t INSTR_OP_ADDI = 4'd1;
    localparam op_t INSTR_OP_SUB  = 4'd2;
    localparam op_t INSTR_OP_AND  = 4'd3;
    localparam op_t INSTR_OP_OR   = 4'd4;
    localparam op_t INSTR_OP_XOR  = 4'd5;
    localparam op_t INSTR_OP_SLL  = 4'd6;
    localparam op_t INSTR_OP_SRL  = 4'd7;

    typedef struct packed {
        op_t        op;
        logic [2:0] funct3;
        reg_idx     rs1;
        reg_idx     rs2;
        reg_idx     rd;
        gpreg       imm;
    } decoded_instr;

    typedef struct packed {
        op_t        op;
        logic [2:0] funct3;
        reg_idx     rd;
        gpreg       imm;
        gpreg       rs1_val;
        gpreg       rs2_val;
    } issued_instr;

    typedef struct packed {
        reg_idx rd_idx;
        gpreg   rd_val;
    } exec_result;

    // A writeback "hits" a register when it targets that register and the
    // register is not x0 (index 0 on the write port means no write).
    function automatic logic wb_hit(exec_result wb, reg_idx r);
        return (wb.rd_idx == r) && (r != '0);
    endfunction

endpackage

// File: rtl/issue_stage_regfile.sv
// Architectural register file for the issue stage.
// Ports:
//   clk, rst        clock, synchronous active-high reset (clears every entry)
//   raddr1/raddr2   combinational read addresses
//   rdata1/rdata2   read data; x0 reads zero, a same-cycle write is bypassed
//   waddr, wdata    synchronous write port; waddr==0 means no write
module issue_stage_regfile #(
    parameter int NREG = 32,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      raddr1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] mem [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (waddr != '0) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (raddr1 != '0) begin
            rdata1 = (waddr == raddr1) ? wdata : mem[raddr1];
        end
        if (raddr2 != '0) begin
            rdata2 = (waddr == raddr2) ? wdata : mem[raddr2];
        end
    end

endmodule

// File: rtl/issue_stage.sv
// Issue stage between decode and the ALU. Reads operands from the register
// file, tracks in-flight destinations in a scoreboard, stalls on RAW/WAW
// hazards and presents one registered instruction per cycle to the ALU.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   instr_valid/ready/data       decoded instruction from decode
//   issued_valid/ready/data      operand-resolved instruction to the ALU
//   wb                           ALU writeback (rd_idx==0 means no write)
//   flush                        drops the output entry and blocks acceptance
module issue_stage
    import issue_stage_pkg::*;
#(
    parameter int NREG = issue_stage_pkg::NREG,
    parameter int XLEN = issue_stage_pkg::XLEN
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         instr_valid,
    output logic         instr_ready,
    input  decoded_instr instr_data,
    output logic         issued_valid,
    input  logic         issued_ready,
    output issued_instr  issued_data,
    input  exec_result   wb,
    input  logic         flush
);

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;
    logic            out_valid;
    issued_instr     out_data;
    logic            haz;
    logic            accept;
    gpreg            rs1_val;
    gpreg            rs2_val;
    issued_instr     new_entry;

    issue_stage_regfile #(
        .NREG (NREG),
        .XLEN (XLEN)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (instr_data.rs1),
        .raddr2 (instr_data.rs2),
        .rdata1 (rs1_val),
        .rdata2 (rs2_val),
        .waddr  (wb.rd_idx),
        .wdata  (wb.rd_val)
    );

    // A busy register is not a hazard if its producer writes back this cycle:
    // the regfile bypass supplies the value and the scoreboard clears it.
    always_comb begin
        haz = ((instr_data.rs1 != '0) && busy[instr_data.rs1] && !wb_hit(wb, instr_data.rs1))
           || ((instr_data.rs2 != '0) && busy[instr_data.rs2] && !wb_hit(wb, instr_data.rs2))
           || ((instr_data.rd  != '0) && busy[instr_data.rd]  && !wb_hit(wb, instr_data.rd));
        instr_ready = !rst && !flush && !haz && (!out_valid || issued_ready);
        accept      = instr_valid && instr_ready;
    end

    always_comb begin
        new_entry         = '0;
        new_entry.op      = instr_data.op;
        new_entry.funct3  = instr_data.funct3;
        new_entry.rd      = instr_data.rd;
        new_entry.imm     = instr_data.imm;
        new_entry.rs1_val = rs1_val;
        new_entry.rs2_val = rs2_val;
    end

    // Clears are applied before the set so a same-cycle set on the same index wins.
    // A flushed entry that never reached the ALU will never write back, so its
    // destination is released here.
    always_comb begin
        busy_next = busy;
        if (wb.rd_idx != '0) begin
            busy_next[wb.rd_idx] = 1'b0;
        end
        if (flush && out_valid && !issued_ready) begin
            busy_next[out_data.rd] = 1'b0;
        end
        if (accept && (instr_data.rd != '0)) begin
            busy_next[instr_data.rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            busy <= busy_next;
            if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                out_data  <= new_entry;
            end else if (issued_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign issued_valid = out_valid;
    assign issued_data  = out_data;

endmodule
